drm_21x64_fifo_ctrl: RTL and testbench
======================================

Name: drm_21x64_fifo_ctrl

Overview:
Single-clock FIFO controller that drives the write and read ports of an external drm_21x64 simple dual-port RAM (64 x 21, unregistered output, 1-cycle read latency) and adds valid/ready streaming on both sides. Upstream producers push through s_*; downstream consumers pop through m_*. A 2-entry registered output buffer hides the RAM read latency, so m_data is first-word-fall-through with full 1 word/cycle throughput. The RAM instance sits beside this block and is wired port-to-port to ram_*.

Parameters:
DATA_WIDTH, 21, word width; must match the RAM data width.
ADDR_WIDTH, 6, RAM address width; DEPTH = 2**ADDR_WIDTH = 64.
AFULL_THRESH, 60, almost_full level; used only with the optional feature.
AEMPTY_THRESH, 2, almost_empty level; used only with the optional feature.

Ports:
clk  in  1  single clock; also drives the RAM wr_clk and rd_clk.
rst_n  in  1  synchronous, active-low reset.
s_valid  in  1  upstream word valid.
s_ready  out  1  controller can accept a word.
s_data  in  DATA_WIDTH  upstream word.
m_valid  out  1  output word valid.
m_ready  in  1  downstream accepts the word.
m_data  out  DATA_WIDTH  output word, registered.
count  out  ADDR_WIDTH+1  total words held: RAM + in-flight read + output buffer; range 0..DEPTH+2.
ram_rst  out  1  active-high RAM reset = ~rst_n; to RAM wr_rst and rd_rst.
ram_wr_en  out  1  RAM write enable = s_valid & s_ready.
ram_wr_addr  out  ADDR_WIDTH  write pointer.
ram_wr_data  out  DATA_WIDTH  = s_data.
ram_rd_addr  out  ADDR_WIDTH  read pointer.
ram_rd_data  in  DATA_WIDTH  RAM read data; valid the cycle after ram_rd_addr is sampled.

Behaviour:
- Reset (rst_n low at posedge): wr_ptr = rd_ptr = 0, ram_cnt = 0, rd_pending = 0, out buffer empty. Outputs: s_ready = 0, m_valid = 0, m_data = 0, count = 0, ram_wr_en = 0. Stored contents are discarded. A reset mid-stream behaves identically.
- s_ready = (ram_cnt < DEPTH) & rst_n. It depends only on registered state, with no combinational path from m_ready or s_valid.
- Push (s_valid & s_ready): RAM writes s_data at wr_ptr on that edge. wr_ptr increments modulo DEPTH (63 -> 0).
- Read issue (issue): asserted when ram_cnt > 0 and (out_cnt + rd_pending - pop) < 2, where pop = m_valid & m_ready. ram_rd_addr = rd_ptr always. On issue, rd_ptr increments modulo DEPTH and rd_pending is set for the next cycle.
- Capture: when rd_pending = 1, ram_rd_data is written into the output buffer at the next edge. The buffer has 2 entries in order; m_data/m_valid present the head.
- ram_cnt_next = ram_cnt + push - issue. Simultaneous push and issue leaves it unchanged. A read issues only for words written on earlier edges, so no same-address collision occurs.
- Latency: a word accepted at edge E0 (into an empty FIFO) gives m_valid = 1 after edge E0+2.
- Streaming: with m_ready = 1 held, 1 word/cycle sustained with no bubbles.
- Capacity: DEPTH+2 = 66 words total. count = ram_cnt + rd_pending + out_cnt.
- m_data holds its value while m_valid & !m_ready. Order is strictly FIFO.
- Pop on empty (m_ready with !m_valid) is ignored. Push while !s_ready is ignored, with no write and no pointer change.

Optional Feature:
Macro DRM_FIFO_LEVEL_FLAGS_EN.
- Defined: adds registered outputs almost_full = (count_next >= AFULL_THRESH) and almost_empty = (count_next <= AEMPTY_THRESH). Both reset to 0 and 1 respectively, and update on the same edge as count.
- Undefined: both ports and their logic are absent.

Test Plan:
1. Hold rst_n = 0 for 20 cycles -> s_ready = 0, m_valid = 0, count = 0, ram_rst = 1; first cycle after release -> s_ready = 1.
2. Push one word 0x1FFFFF, m_ready = 1 -> m_valid high exactly 2 cycles after the accept edge, m_data = 0x1FFFFF for one cycle, count returns to 0.
3. m_ready = 0, push descending 0x1FFFFF.. until s_ready falls -> exactly 66 words accepted, count = 66. Then m_ready = 1 -> 66 words out in order, m_valid continuous, ram_rd_addr wraps 63 -> 0.
4. s_valid = 1 and m_ready = 1 continuous for 200 words -> 1 word/cycle after the initial 2-cycle latency, count stays at or below 3.
5. 1000 words with random s_valid and m_ready (50%) -> scoreboard match, no loss or duplication; m_data stable while stalled.
6. Reset asserted with 30 words stored -> after release count = 0, m_valid = 0, and the next pushed word (0x00ABC) is the first out. With DRM_FIFO_LEVEL_FLAGS_EN, almost_full rises on the edge count reaches 60.

Source files
------------

// File: rtl/drm_21x64_fifo_ctrl.sv
// Single-clock valid/ready FIFO controller for an external 64x21 simple dual-port RAM.
// Optional registered almost_full/almost_empty flags: define DRM_FIFO_LEVEL_FLAGS_EN.
module drm_21x64_fifo_ctrl #(
   parameter int unsigned DATA_WIDTH    = 21,
   parameter int unsigned ADDR_WIDTH    = 6,
   parameter int unsigned AFULL_THRESH  = 60,
   parameter int unsigned AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [ADDR_WIDTH:0]   count,
`ifdef DRM_FIFO_LEVEL_FLAGS_EN
   output logic                  almost_full,
   output logic                  almost_empty,
`endif
   output logic                  ram_rst,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CntOne   = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PtrOne   = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  rd_pending_q;
   logic [1:0]            out_cnt_q, out_cnt_d;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
   logic                  push, pop, issue;
   logic [2:0]            occ_after;

   assign s_ready = (ram_cnt_q < DepthCnt) & rst_n;
   assign m_valid = (out_cnt_q != 2'd0);
   assign m_data  = buf0_q;
   assign count   = count_q;

   assign push = s_valid & s_ready;
   assign pop  = m_valid & m_ready;

   // Occupancy of the output stage (buffer + in-flight read) once this cycle's pop retires.
   assign occ_after = {1'b0, out_cnt_q} + {2'b00, rd_pending_q} - {2'b00, pop};
   assign issue     = (ram_cnt_q != '0) && (occ_after < 3'd2);

   assign ram_rst     = ~rst_n;
   assign ram_wr_en   = push;
   assign ram_wr_addr = wr_ptr_q;
   assign ram_wr_data = s_data;
   assign ram_rd_addr = rd_ptr_q;

   always_comb begin
      buf0_d    = buf0_q;
      buf1_d    = buf1_q;
      out_cnt_d = out_cnt_q;
      if (pop) begin
         buf0_d    = buf1_q;
         out_cnt_d = out_cnt_q - 2'd1;
      end
      // Append the returning RAM word behind whatever survives the pop.
      if (rd_pending_q) begin
         if (out_cnt_d == 2'd0) begin
            buf0_d = ram_rd_data;
         end else begin
            buf1_d = ram_rd_data;
         end
         out_cnt_d = out_cnt_d + 2'd1;
      end
   end

   always_comb begin
      ram_cnt_d = ram_cnt_q;
      unique case ({push, issue})
         2'b10:   ram_cnt_d = ram_cnt_q + CntOne;
         2'b01:   ram_cnt_d = ram_cnt_q - CntOne;
         default: ram_cnt_d = ram_cnt_q;
      endcase
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ram_cnt_q    <= '0;
         count_q      <= '0;
         rd_pending_q <= 1'b0;
         out_cnt_q    <= 2'd0;
         buf0_q       <= '0;
         buf1_q       <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrOne;
         end
         if (issue) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
         ram_cnt_q    <= ram_cnt_d;
         count_q      <= count_d;
         rd_pending_q <= issue;
         out_cnt_q    <= out_cnt_d;
         buf0_q       <= buf0_d;
         buf1_q       <= buf1_d;
      end
   end

`ifdef DRM_FIFO_LEVEL_FLAGS_EN
   localparam logic [ADDR_WIDTH:0] AfullLvl  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AemptyLvl = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

   logic almost_full_q, almost_empty_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
      end else begin
         almost_full_q  <= (count_d >= AfullLvl);
         almost_empty_q <= (count_d <= AemptyLvl);
      end
   end

   assign almost_full  = almost_full_q;
   assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_drm_21x64_fifo_ctrl.sv
// Directed and randomized bench for drm_21x64_fifo_ctrl with a behavioural 64x21 RAM beside it.
// Define DRM_FIFO_LEVEL_FLAGS_EN to also check the level flags.
module tb_drm_21x64_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid, s_ready, m_valid, m_ready;
   logic [20:0] s_data, m_data;
   logic [6:0]  count;
   logic        ram_rst, ram_wr_en;
   logic [5:0]  ram_wr_addr, ram_rd_addr;
   logic [20:0] ram_wr_data, ram_rd_data;
`ifdef DRM_FIFO_LEVEL_FLAGS_EN
   logic        almost_full, almost_empty;
`endif

   logic [20:0] mem [64];
   logic [20:0] exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic        prev_stall = 1'b0;
   logic [20:0] prev_data = '0;

   always #5 clk = ~clk;

   drm_21x64_fifo_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .count       (count),
`ifdef DRM_FIFO_LEVEL_FLAGS_EN
      .almost_full (almost_full),
      .almost_empty(almost_empty),
`endif
      .ram_rst     (ram_rst),
      .ram_wr_en   (ram_wr_en),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data)
   );

   // RAM model: synchronous write, address registered, data out one cycle later.
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      ram_rd_data <= mem[ram_rd_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard and stall-stability monitor on every handshake edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", 32'(m_data), 32'(prev_data));
         end
         if (m_valid && m_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
         end
         if (s_valid && s_ready) exp_q.push_back(s_data);
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int          accepted, pushed, popped, cyc, first_valid, gaps, max_cnt;
   logic        will_push, will_pop, saw_wrap;
   logic [5:0]  prev_addr;
   logic [20:0] val;

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

      // 1. Reset state
      repeat (20) @(posedge clk);
      #1;
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_ram_rst", 32'(ram_rst), 32'd1);
      check("rst_wr_en", 32'(ram_wr_en), 32'd0);
`ifdef DRM_FIFO_LEVEL_FLAGS_EN
      check("rst_afull", 32'(almost_full), 32'd0);
      check("rst_aempty", 32'(almost_empty), 32'd1);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rel_s_ready", 32'(s_ready), 32'd1);
      check("rel_ram_rst", 32'(ram_rst), 32'd0);

      // 2. Single word latency
      s_valid = 1'b1; s_data = 21'h1FFFFF; m_ready = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      check("one_cnt_e0", 32'(count), 32'd1);
      check("one_valid_e0", 32'(m_valid), 32'd0);
      @(posedge clk); #1;
      check("one_valid_e1", 32'(m_valid), 32'd0);
      @(posedge clk); #1;
      check("one_valid_e2", 32'(m_valid), 32'd1);
      check("one_data_e2", 32'(m_data), 32'h1FFFFF);
      @(posedge clk); #1;
      check("one_valid_e3", 32'(m_valid), 32'd0);
      check("one_cnt_e3", 32'(count), 32'd0);

      // 3. Fill to capacity, then drain
      m_ready = 1'b0; accepted = 0; val = 21'h1FFFFF;
      for (int i = 0; i < 200; i++) begin
`ifdef DRM_FIFO_LEVEL_FLAGS_EN
         check("fill_afull", 32'(almost_full), 32'(accepted >= 60));
         check("fill_aempty", 32'(almost_empty), 32'(accepted <= 2));
`endif
         if (!s_ready) break;
         s_valid = 1'b1; s_data = val;
         @(posedge clk); #1;
         accepted++; val = val - 21'd1;
      end
      s_valid = 1'b0;
      check("fill_accepted", 32'(accepted), 32'd66);
      check("fill_count", 32'(count), 32'd66);
      @(posedge clk); #1;
      check("fill_s_ready", 32'(s_ready), 32'd0);
      check("fill_count_hold", 32'(count), 32'd66);
      m_ready = 1'b1; gaps = 0; saw_wrap = 1'b0; prev_addr = ram_rd_addr;
      for (int i = 0; i < 66; i++) begin
         if (!m_valid) gaps++;
         check("drain_data", 32'(m_data), 32'(21'h1FFFFF - 21'(i)));
         @(posedge clk); #1;
         if (prev_addr == 6'd63 && ram_rd_addr == 6'd0) saw_wrap = 1'b1;
         prev_addr = ram_rd_addr;
      end
      check("drain_gaps", 32'(gaps), 32'd0);
      check("drain_wrap", 32'(saw_wrap), 32'd1);
      check("drain_empty", 32'(m_valid), 32'd0);
      check("drain_count", 32'(count), 32'd0);

      // 4. Sustained streaming
      pushed = 0; popped = 0; cyc = 0; first_valid = -1; gaps = 0; max_cnt = 0;
      while (popped < 200 && cyc < 400) begin
         s_valid = (pushed < 200); s_data = 21'h100 + 21'(pushed);
         if (m_valid) begin
            check("stream_data", 32'(m_data), 32'(21'h100 + 21'(popped)));
            if (first_valid < 0) first_valid = cyc;
         end else if (first_valid >= 0) begin
            gaps++;
         end
         if (int'(count) > max_cnt) max_cnt = int'(count);
         will_push = s_valid && s_ready; will_pop = m_valid;
         @(posedge clk); #1;
         cyc++;
         if (will_push) pushed++;
         if (will_pop) popped++;
      end
      s_valid = 1'b0;
      check("stream_popped", 32'(popped), 32'd200);
      check("stream_latency", 32'(first_valid), 32'd3);
      check("stream_gaps", 32'(gaps), 32'd0);
      check("stream_max_cnt", 32'(max_cnt <= 3), 32'd1);

      // 5. Random traffic against the scoreboard
      pushed = 0; popped = 0; cyc = 0;
      while ((pushed < 1000 || popped < 1000) && cyc < 20000) begin
         s_valid = (pushed < 1000) && ($urandom_range(0, 1) == 1);
         s_data  = 21'($urandom);
         m_ready = ($urandom_range(0, 1) == 1);
         will_push = s_valid && s_ready; will_pop = m_valid && m_ready;
         @(posedge clk); #1;
         cyc++;
         if (will_push) pushed++;
         if (will_pop) popped++;
      end
      s_valid = 1'b0; m_ready = 1'b0;
      check("rand_popped", 32'(popped), 32'd1000);
      check("rand_sb_empty", 32'(exp_q.size()), 32'd0);
      check("rand_count", 32'(count), 32'd0);

      // 6. Reset with words stored
      for (int i = 0; i < 30; i++) begin
         s_valid = 1'b1; s_data = 21'h5000 + 21'(i);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      check("pre_rst_count", 32'(count), 32'd30);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("mid_rst_s_ready", 32'(s_ready), 32'd0);
      check("mid_rst_count", 32'(count), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_count", 32'(count), 32'd0);
      check("post_rst_valid", 32'(m_valid), 32'd0);
      s_valid = 1'b1; s_data = 21'h00ABC; m_ready = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      cyc = 0;
      while (!m_valid && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("post_rst_seen", 32'(m_valid), 32'd1);
      check("post_rst_data", 32'(m_data), 32'h00ABC);
      @(posedge clk); #1;
      check("post_rst_final", 32'(count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
